// File: rtl/regfile_fill_scan_if.sv
// Register file bus: write port, read ports, fill control and scan outputs.
// Master drives requests; slave (the register file) returns data and status.
interface regfile_fill_scan_if #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int NRD = 2
);
  logic             we;
  logic [N-1:0]     addr_wr;
  logic [W-1:0]     data_wr;
  logic [NRD*N-1:0] rd_addr;
  logic [NRD*W-1:0] rd_data;
  logic             fill_start;
  logic             fill_busy;
  logic             fill_done;
  logic             scan_en;
  logic [N-1:0]     scan_addr;
  logic [W-1:0]     scan_data;

  modport master (
    output we, addr_wr, data_wr, rd_addr,
    output fill_start, scan_en,
    input  rd_data, fill_busy, fill_done,
    input  scan_addr, scan_data
  );

  modport slave (
    input  we, addr_wr, data_wr, rd_addr,
    input  fill_start, scan_en,
    output rd_data, fill_busy, fill_done,
    output scan_addr, scan_data
  );
endinterface

// File: rtl/regfile_fill_scan.sv
// Register file with LFSR fill engine and display scan counter.
// Optional ZERO_REG_EN: reg[0] hard-wired to zero.
module regfile_fill_scan #(
  parameter int          N          = 4,
  parameter int          W          = 8,
  parameter int          NRD        = 2,
  parameter int          SCAN_TICKS = 100000000,
  parameter logic [W-1:0] LFSR_TAPS = 'hB8,
  parameter logic [W-1:0] LFSR_SEED = 'h01
) (
  input logic clk,
  input logic rst,
  regfile_fill_scan_if.slave bus
);
  localparam int D  = 1 << N;
  localparam int CW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [CW-1:0] TMAX = CW'(SCAN_TICKS - 1);
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_n;
  logic [N-1:0]   r_ptr;
  logic [W-1:0]   r_lfsr;
  logic [W-1:0]   w_lfsr_n;
  logic [W-1:0]   r_mem [D];
  logic [W-1:0]   w_mem [D];
  logic [CW-1:0]  r_scan_cnt;
  logic [N-1:0]   r_scan_addr;
  logic           w_fill_we;
  logic           w_ext_we;
  logic           w_last;

  assign w_last    = (r_ptr == N'(D - 1));
  assign w_fill_we = (r_state == S_FILL);
  assign w_ext_we  = bus.we && !w_fill_we;
  assign w_lfsr_n  = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS)
                               : (r_lfsr >> 1);

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.fill_start) w_state_n = S_FILL;
      S_FILL:  if (w_last) w_state_n = S_DONE;
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // lfsr only advances on fill writes, so back-to-back fills continue the sequence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_lfsr <= LFSR_SEED;
    end else if (w_fill_we) begin
      r_ptr  <= r_ptr + 1'b1;
      r_lfsr <= w_lfsr_n;
    end else begin
      r_ptr  <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
    end else if (w_fill_we) begin
      if (!(ZR && r_ptr == '0)) r_mem[r_ptr] <= r_lfsr;
    end else if (w_ext_we) begin
      if (!(ZR && bus.addr_wr == '0))
        r_mem[bus.addr_wr] <= bus.data_wr;
    end
  end

  always_comb begin
    for (int i = 0; i < D; i++) w_mem[i] = r_mem[i];
    if (ZR) w_mem[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_scan_addr <= '0;
    end else if (!bus.scan_en) begin
      r_scan_cnt  <= '0;
    end else if (r_scan_cnt == TMAX) begin
      r_scan_cnt  <= '0;
      r_scan_addr <= r_scan_addr + 1'b1;
    end else begin
      r_scan_cnt  <= r_scan_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    assign bus.rd_data[k*W +: W] = w_mem[bus.rd_addr[k*N +: N]];
  end

  assign bus.fill_busy = (r_state == S_FILL);
  assign bus.fill_done = (r_state == S_DONE);
  assign bus.scan_addr = r_scan_addr;
  assign bus.scan_data = w_mem[r_scan_addr];
endmodule

// File: tb/tb_regfile_fill_scan.sv
// Randomized bench for regfile_fill_scan against an array/arithmetic model.
`timescale 1ns/100ps
module tb_regfile_fill_scan;
  localparam int N = 4, W = 8, NRD = 2, ST = 4, D = 16;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_fill_scan_if #(.N(N), .W(W), .NRD(NRD)) bus ();

  regfile_fill_scan #(
    .N(N), .W(W), .NRD(NRD), .SCAN_TICKS(ST),
    .LFSR_TAPS(8'hB8), .LFSR_SEED(8'h01)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] mref [D];
  int m_lfsr;
  int sc_base, sc_len;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] m_rd(int a);
    if (ZR && a == 0) return '0;
    return mref[a];
  endfunction

  function automatic int m_next(int x);
    if (x % 2 == 1) return (x / 2) ^ 'hB8;
    return x / 2;
  endfunction

  task automatic m_wr(int a, logic [W-1:0] d);
    if (!(ZR && a == 0)) mref[a] = d;
  endtask

  task automatic m_reset();
    for (int i = 0; i < D; i++) mref[i] = '0;
    m_lfsr  = 1;
    sc_base = 0;
    sc_len  = 0;
  endtask

  task automatic m_fill();
    for (int i = 0; i < D; i++) begin
      m_wr(i, W'(m_lfsr));
      m_lfsr = m_next(m_lfsr);
    end
  endtask

  function automatic int sc_exp();
    return (sc_base + sc_len / ST) % D;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.we = 1'b0;
    bus.addr_wr = '0;
    bus.data_wr = '0;
    bus.fill_start = 1'b0;
  endtask

  task automatic set_rd(int a0, int a1);
    bus.rd_addr = {N'(a1), N'(a0)};
  endtask

  task automatic chk_rd(string tag);
    #1;
    for (int k = 0; k < NRD; k++)
      check(tag, 32'(bus.rd_data[k*W +: W]),
            32'(m_rd(int'(bus.rd_addr[k*N +: N]))));
  endtask

  task automatic check_all(string tag);
    for (int a = 0; a < D; a += NRD) begin
      set_rd(a, a + 1);
      chk_rd(tag);
    end
  endtask

  task automatic fill_wait(input bit disturb, output int cyc);
    cyc = 0;
    while (bus.fill_busy && cyc < 40) begin
      if (disturb && cyc < 12) begin
        bus.we = 1'b1;
        bus.addr_wr = 4'd5;
        bus.data_wr = 8'hFF;
        bus.fill_start = 1'b1;
      end else begin
        idle_in();
      end
      if (bus.fill_done) check("done_in_fill", 32'(bus.fill_done), 0);
      tick();
      cyc++;
    end
    idle_in();
  endtask

  task automatic run_fill(input bit disturb, input bit restart);
    int cyc;
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
    check("busy_start", 32'(bus.fill_busy), 1);
    fill_wait(disturb, cyc);
    check("busy_len", 32'(cyc), 16);
    check("done_pulse", 32'(bus.fill_done), 1);
    m_fill();
    if (restart) begin
      bus.fill_start = 1'b1;
      tick();
      check("rs_idle_busy", 32'(bus.fill_busy), 0);
      check("rs_idle_done", 32'(bus.fill_done), 0);
      tick();
      bus.fill_start = 1'b0;
      check("rs_busy", 32'(bus.fill_busy), 1);
      fill_wait(1'b0, cyc);
      check("rs_busy_len", 32'(cyc), 16);
      check("rs_done", 32'(bus.fill_done), 1);
      m_fill();
    end
    tick();
    check("done_1cyc", 32'(bus.fill_done), 0);
    check("busy_end", 32'(bus.fill_busy), 0);
  endtask

  task automatic scan_run(int len, bit en);
    bus.scan_en = en;
    for (int i = 0; i < len; i++) begin
      tick();
      if (en) begin
        sc_len++;
      end else begin
        sc_base = sc_exp();
        sc_len  = 0;
      end
      check("scan_addr", 32'(bus.scan_addr), 32'(sc_exp()));
      check("scan_data", 32'(bus.scan_data), 32'(m_rd(sc_exp())));
    end
  endtask

  int dn;

  initial begin
    rst = 1'b1;
    idle_in();
    bus.scan_en = 1'b0;
    set_rd(0, 0);
    m_reset();
    #3;
    check("rst_busy", 32'(bus.fill_busy), 0);
    check("rst_done", 32'(bus.fill_done), 0);
    check("rst_scan", 32'(bus.scan_addr), 0);
    #4 rst = 1'b0;
    tick();
    check_all("rst_regs");

    bus.we = 1'b1;
    bus.addr_wr = 4'd3;
    bus.data_wr = 8'h5A;
    set_rd(3, 3);
    chk_rd("wr_before");
    tick();
    m_wr(3, 8'h5A);
    idle_in();
    check("wr3_p0", 32'(bus.rd_data[7:0]), 32'h5A);
    check("wr3_p1", 32'(bus.rd_data[15:8]), 32'h5A);

    for (int i = 0; i < 40; i++) begin
      bus.we = 1'($urandom_range(0, 1));
      bus.addr_wr = N'($urandom_range(0, D - 1));
      bus.data_wr = W'($urandom);
      set_rd($urandom_range(0, D - 1), $urandom_range(0, D - 1));
      chk_rd("rnd_rd");
      @(posedge clk);
      if (bus.we) m_wr(int'(bus.addr_wr), bus.data_wr);
      #1;
    end
    idle_in();
    check_all("rnd_all");

    #2 rst = 1'b1;
    #1;
    m_reset();
    check_all("rst_pulse");
    rst = 1'b0;
    tick();

    run_fill(1'b1, 1'b0);
    set_rd(0, 1);
    #1;
    check("fill_r0", 32'(bus.rd_data[7:0]), ZR ? 32'h00 : 32'h01);
    check("fill_r1", 32'(bus.rd_data[15:8]), 32'hB8);
    set_rd(2, 3);
    #1;
    check("fill_r2", 32'(bus.rd_data[7:0]), 32'h5C);
    check("fill_r3", 32'(bus.rd_data[15:8]), 32'h2E);
    check_all("fill1");

    run_fill(1'b0, 1'b1);
    check_all("fill23");

    for (int i = 0; i < 6; i++) begin
      bus.we = 1'b1;
      bus.addr_wr = N'($urandom_range(0, D - 1));
      bus.data_wr = W'($urandom);
      tick();
      m_wr(int'(bus.addr_wr), bus.data_wr);
    end
    idle_in();

    scan_run(70, 1'b1);
    scan_run(5, 1'b0);
    scan_run(3, 1'b1);
    scan_run(2, 1'b0);
    scan_run(3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      scan_run($urandom_range(1, 12), 1'b1);
      scan_run($urandom_range(1, 3), 1'b0);
    end
    scan_run(9, 1'b1);

    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
    repeat (8) tick();
    #2 rst = 1'b1;
    #1;
    m_reset();
    check("mid_busy", 32'(bus.fill_busy), 0);
    check("mid_done", 32'(bus.fill_done), 0);
    check("mid_scan", 32'(bus.scan_addr), 0);
    #2 rst = 1'b0;
    bus.scan_en = 1'b0;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.fill_done || bus.fill_busy) dn++;
    end
    check("mid_no_done", 32'(dn), 0);
    check_all("mid_regs");

    run_fill(1'b0, 1'b0);
    set_rd(0, 1);
    #1;
    check("refill_r0", 32'(bus.rd_data[7:0]), ZR ? 32'h00 : 32'h01);
    check("refill_r1", 32'(bus.rd_data[15:8]), 32'hB8);
    check_all("refill");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=done", n_chk);
    $fatal(1, "timeout");
  end
endmodule
